// File: rtl/align_batch_sched.sv
// Batch scheduler ahead of the alignment stage: buffers up to DEPTH partial
// products, tracks the batch max exponent, then issues them one per cycle.
module align_batch_sched #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned EXP_W = 6,
  parameter int unsigned PP_W  = 4,
  parameter int unsigned QF_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  in_pp,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [QF_W-1:0]  in_Q_frac,
  input  logic             in_last,
  output logic             o_valid,
  output logic [PP_W-1:0]  o_denorm_pp,
  output logic [EXP_W-1:0] o_exp,
  output logic [EXP_W-1:0] o_max_exp,
  output logic [QF_W-1:0]  o_Q_frac,
  output logic [3:0]       o_lane,
  output logic             o_last,
  output logic             o_busy
);

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  typedef enum logic {
    COLLECT,
    ISSUE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic [3:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [EXP_W-1:0] max_q, max_d;
  logic             seen_q, seen_d;
  logic [QF_W-1:0]  qf_q, qf_d;

  logic [PP_W-1:0]  pp_mem_q  [DEPTH];
  logic [EXP_W-1:0] exp_mem_q [DEPTH];

  logic             accept;
  logic             live;
  logic             base_seen;
  logic [EXP_W-1:0] base_max;

  assign accept    = in_valid && (state_q == COLLECT);
  assign live      = |in_pp[PP_W-2:0];
  // The first beat of a batch starts the max search fresh, so no clear is needed between batches.
  assign base_seen = (wr_ptr_q == '0) ? 1'b0 : seen_q;
  assign base_max  = (wr_ptr_q == '0) ? '0 : max_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      max_q    <= '0;
      seen_q   <= 1'b0;
      qf_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      seen_q   <= seen_d;
      qf_q     <= qf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      pp_mem_q[wr_ptr_q]  <= in_pp;
      exp_mem_q[wr_ptr_q] <= in_exp;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    seen_d   = seen_q;
    qf_d     = qf_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 4'd1;
          if (wr_ptr_q == '0) qf_d = in_Q_frac;
          max_d  = base_max;
          seen_d = base_seen;
          if (live) begin
            seen_d = 1'b1;
            if (!base_seen || (in_exp > base_max)) max_d = in_exp;
          end
          if (in_last || (wr_ptr_q == LAST_IDX)) begin
            cnt_d    = wr_ptr_q + 4'd1;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rd_ptr_q == cnt_q - 4'd1) begin
          state_d  = COLLECT;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + 4'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == COLLECT);
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    o_denorm_pp = '0;
    o_exp       = '0;
    o_max_exp   = '0;
    o_Q_frac    = '0;
    o_lane      = '0;
    o_last      = 1'b0;
    if (state_q == ISSUE) begin
      o_valid     = 1'b1;
      o_busy      = 1'b1;
      o_denorm_pp = pp_mem_q[rd_ptr_q];
      o_exp       = exp_mem_q[rd_ptr_q];
      o_max_exp   = max_q;
      o_Q_frac    = qf_q;
      o_lane      = rd_ptr_q;
      o_last      = (rd_ptr_q == cnt_q - 4'd1);
    end
  end

endmodule

// File: tb/tb_align_batch_sched.sv
// Scoreboard bench for align_batch_sched: expected issue beats are queued as
// batches are driven and compared as the scheduler issues them.
module tb_align_batch_sched;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_pp;
  logic [5:0] in_exp;
  logic [4:0] in_Q_frac;
  logic       in_last;
  logic       o_valid;
  logic [3:0] o_denorm_pp;
  logic [5:0] o_exp;
  logic [5:0] o_max_exp;
  logic [4:0] o_Q_frac;
  logic [3:0] o_lane;
  logic       o_last;
  logic       o_busy;

  typedef struct packed {
    logic [3:0] pp;
    logic [5:0] exp;
    logic [5:0] mx;
    logic [4:0] qf;
    logic [3:0] lane;
    logic       last;
    logic       busy;
  } beat_t;

  beat_t sb[$];
  beat_t obs, exp_b;
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  logic [3:0] bpp  [16];
  logic [5:0] bexp [16];

  align_batch_sched #(
    .DEPTH(9),
    .EXP_W(6),
    .PP_W (4),
    .QF_W (5)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pp      (in_pp),
    .in_exp     (in_exp),
    .in_Q_frac  (in_Q_frac),
    .in_last    (in_last),
    .o_valid    (o_valid),
    .o_denorm_pp(o_denorm_pp),
    .o_exp      (o_exp),
    .o_max_exp  (o_max_exp),
    .o_Q_frac   (o_Q_frac),
    .o_lane     (o_lane),
    .o_last     (o_last),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  // Issue-side monitor: every valid beat must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_valid !== 1'b0) begin
      obs.pp   = o_denorm_pp;
      obs.exp  = o_exp;
      obs.mx   = o_max_exp;
      obs.qf   = o_Q_frac;
      obs.lane = o_lane;
      obs.last = o_last;
      obs.busy = o_busy;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_issue got=%h required=no_beat", obs);
        failures++;
      end else begin
        exp_b = sb.pop_front();
        if (obs !== exp_b) begin
          $display("FAIL issue_beat lane=%0d got=%h required=%h", exp_b.lane, obs, exp_b);
          failures++;
        end
      end
    end
  end

  task automatic send_batch(input int n, input logic [4:0] qf, input bit use_last,
                            input bit hold, output int first_cyc, output int last_cyc);
    beat_t      e;
    logic [5:0] mx;
    bit         seen;
    int         tries;
    mx   = '0;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bpp[i][2:0] != 3'b000) begin
        if (!seen || bexp[i] > mx) mx = bexp[i];
        seen = 1'b1;
      end
    end
    for (int i = 0; i < n; i++) begin
      e.pp   = bpp[i];
      e.exp  = bexp[i];
      e.mx   = mx;
      e.qf   = qf;
      e.lane = 4'(i);
      e.last = (i == n - 1);
      e.busy = 1'b1;
      sb.push_back(e);
    end
    first_cyc = 0;
    last_cyc  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      in_valid  = 1'b1;
      in_pp     = bpp[i];
      in_exp    = bexp[i];
      in_Q_frac = (i == 0) ? qf : ~qf;
      in_last   = use_last && (i == n - 1);
      tries = 0;
      while (in_ready !== 1'b1 && tries < 64) begin
        @(negedge i_clk);
        tries++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL accept_timeout beat=%0d in_ready=%b required=1", i, in_ready);
        failures++;
      end
      @(posedge i_clk);
      #1;
      if (i == 0) first_cyc = cyc;
      if (i == n - 1) last_cyc = cyc;
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    in_valid  = 1'b0;
    in_pp     = '0;
    in_exp    = '0;
    in_Q_frac = '0;
    in_last   = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_ready got=%b required=1", in_ready);
      failures++;
    end
    checks++;
    if ({o_valid, o_denorm_pp, o_exp, o_max_exp, o_Q_frac, o_lane, o_last, o_busy} !== '0) begin
      $display("FAIL reset_outputs got=%h required=0",
               {o_valid, o_denorm_pp, o_exp, o_max_exp, o_Q_frac, o_lane, o_last, o_busy});
      failures++;
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic3();
    int f, l;
    bpp[0] = 4'b0100; bexp[0] = 6'd5;
    bpp[1] = 4'b0100; bexp[1] = 6'd12;
    bpp[2] = 4'b0100; bexp[2] = 6'd7;
    send_batch(3, 5'd3, 1'b1, 1'b0, f, l);
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      checks++;
      if ({in_ready, o_busy} !== ((k == 4) ? 2'b10 : 2'b01)) begin
        $display("FAIL basic3_ready t+%0d got ready=%b busy=%b required ready=%0d",
                 k, in_ready, o_busy, (k == 4));
        failures++;
      end
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL basic3_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  task automatic test_full9();
    int f, l;
    for (int i = 0; i < 9; i++) begin
      bpp[i]  = 4'b0001;
      bexp[i] = 6'(i);
    end
    send_batch(9, 5'd17, 1'b0, 1'b0, f, l);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL full9_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  task automatic test_zero_mag();
    int f, l;
    bpp[0] = 4'b1000; bexp[0] = 6'd30;
    bpp[1] = 4'b0110; bexp[1] = 6'd10;
    bpp[2] = 4'b0000; bexp[2] = 6'd20;
    send_batch(3, 5'd21, 1'b1, 1'b0, f, l);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL zero_mag_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  task automatic test_all_zero();
    int f, l;
    bpp[0] = 4'b0000; bexp[0] = 6'd9;
    bpp[1] = 4'b1000; bexp[1] = 6'd5;
    send_batch(2, 5'd30, 1'b1, 1'b0, f, l);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL all_zero_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    int fa, la, fb, lb;
    bpp[0] = 4'b0010; bexp[0] = 6'd3;
    bpp[1] = 4'b0010; bexp[1] = 6'd9;
    send_batch(2, 5'd4, 1'b1, 1'b1, fa, la);
    bpp[0] = 4'b1011; bexp[0] = 6'd4;
    bpp[1] = 4'b0000; bexp[1] = 6'd1;
    bpp[2] = 4'b0101; bexp[2] = 6'd6;
    send_batch(3, 5'd11, 1'b1, 1'b0, fb, lb);
    checks++;
    if (fb - la != 3) begin
      $display("FAIL b2b_restart gap got=%0d required=3", fb - la);
      failures++;
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL b2b_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    int f, l;
    for (int i = 0; i < 4; i++) begin
      bpp[i]  = 4'b0111;
      bexp[i] = 6'(40 + i);
    end
    send_batch(4, 5'd7, 1'b1, 1'b0, f, l);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({o_valid, in_ready, o_busy, o_lane} !== 7'b010_0000) begin
      $display("FAIL reset_mid got valid=%b ready=%b busy=%b lane=%0d required valid=0 ready=1 busy=0 lane=0",
               o_valid, in_ready, o_busy, o_lane);
      failures++;
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bpp[0] = 4'b0001; bexp[0] = 6'd2;
    bpp[1] = 4'b0001; bexp[1] = 6'd1;
    send_batch(2, 5'd9, 1'b1, 1'b0, f, l);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL reset_mid_drain left=%0d required=0", sb.size());
      failures++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic3();
    test_full9();
    test_zero_mag();
    test_all_zero();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/align_batch_sched.md
Name: align_batch_sched

Overview:
- Scheduler in front of the alignment stage of the MAC subsystem.
- Collects one batch of up to DEPTH partial products from the multiplier lanes, and computes the batch maximum exponent while collecting.
- Then issues the buffered partial products to the alignment datapath one per cycle, each with the batch max exponent, Q_frac and lane index.
- Decouples bursty multiplier output from the single-issue, no-backpressure alignment pipeline.

Parameters:
- DEPTH, 9: maximum partial products per batch (lanes 0..DEPTH-1).
- EXP_W, 6: exponent width.
- PP_W, 4: denormalised partial-product width; bit PP_W-1 is the sign, the rest is the magnitude.
- QF_W, 5: Q_frac width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  scheduler can accept a beat.
- in_pp  in  PP_W  denorm_pp of the beat.
- in_exp  in  EXP_W  exponent of the beat.
- in_Q_frac  in  QF_W  fraction position; sampled on the first beat of a batch only.
- in_last  in  1  final beat of the batch.
- o_valid  out  1  issue beat valid, to the alignment stage i_valid.
- o_denorm_pp  out  PP_W  buffered partial product.
- o_exp  out  EXP_W  buffered exponent.
- o_max_exp  out  EXP_W  batch maximum exponent.
- o_Q_frac  out  QF_W  batch Q_frac.
- o_lane  out  4  buffer index of the issued beat.
- o_last  out  1  final issued beat of the batch.
- o_busy  out  1  high whenever state is ISSUE.

Behaviour:
- Reset: state COLLECT; wr_ptr = 0, rd_ptr = 0, cnt = 0, max_reg = 0.
  - All outputs are 0 except in_ready = 1.
  - Buffer contents are not reset.
  - An assertion of reset mid-batch discards the batch; no partial issue follows.
- Accept condition: a beat is accepted when in_valid && in_ready.
- in_ready is combinational from state: 1 in COLLECT, 0 in ISSUE.
- COLLECT, on each accepted beat:
  - Write {in_pp, in_exp} to buf[wr_ptr] and increment wr_ptr.
  - On the first beat (wr_ptr == 0), latch in_Q_frac.
- Max rule:
  - A beat is "live" if in_pp[PP_W-2:0] != 0.
  - Live beats update max_reg = (first live beat of batch) ? in_exp : max(max_reg, in_exp), using an unsigned compare.
  - Zero-magnitude beats are buffered but do not affect max_reg.
  - If the batch has no live beat, max_reg = 0.
- Batch end is an accepted beat with in_last = 1, or the accepted beat at wr_ptr == DEPTH-1 (implicit last). On batch end:
  - cnt = wr_ptr + 1 and rd_ptr = 0.
  - Next state is ISSUE.
- ISSUE: one beat is registered out per cycle, starting the cycle after the last beat is accepted.
  - o_valid = 1; o_denorm_pp and o_exp come from buf[rd_ptr].
  - o_lane = rd_ptr.
  - o_max_exp and o_Q_frac come from the latched batch values, constant for the whole batch.
  - o_last = 1 when rd_ptr == cnt-1.
  - After the o_last beat: state returns to COLLECT, wr_ptr = 0, and o_valid drops the next cycle.
- Latency: a batch of N beats whose last beat is accepted in cycle t issues in cycles t+1..t+N, is back-to-back with no bubbles, and in_ready = 1 from cycle t+N+1.
- No backpressure on the issue side: the alignment stage always consumes.
- in_valid is ignored in ISSUE; the producer must hold its beat until in_ready.
- Consistency: o_max_exp - o_exp is never negative for live beats, so the alignment SUB never borrows.
- Arithmetic is unsigned with no wrap; pointers are 4 bits wide and never exceed DEPTH-1.

Test Plan:
- 3-beat batch, exps 5, 12, 7, all pp = 4'b0100, Q_frac = 3, last on beat 3 -> issue in cycles t+1..t+3:
  - o_max_exp = 12 on all three beats, o_Q_frac = 3.
  - o_lane = 0, 1, 2; o_last only on lane 2.
  - in_ready returns high at t+4.
- 9 beats, no in_last, exps 0..8 -> implicit last after lane 8; 9 issue beats with o_max_exp = 8 and o_last on lane 8.
- Batch exps 30 (pp = 4'b1000), 10 (pp = 4'b0110), 20 (pp = 4'b0000) -> o_max_exp = 10, because beats with zero magnitude are excluded. Sign-only 4'b1000 is treated as zero.
- All-zero batch of 2 beats -> o_max_exp = 0; both beats issued.
- Hold in_valid = 1 continuously across two batches -> no beats accepted while o_busy = 1; the second batch begins the cycle after the first o_last, and no beat is lost or duplicated.
- Deassert i_rst_n during the 2nd issue beat of a 4-beat batch -> o_valid = 0 immediately, in_ready = 1; the next batch issues from lane 0 with a fresh max.
